// File: rtl/bypass_fifo_pkg.sv
// Shared types and helpers for bypass_fifo.
//   op_e      : the single state-update action taken in a cycle
//   decode_op : maps accepted enqueue/dequeue plus emptiness onto op_e
package bypass_fifo_pkg;

    typedef enum logic [2:0] {
        OP_NONE,      // no accepted request
        OP_PUSH,      // enqueue only
        OP_POP,       // dequeue only
        OP_PUSH_POP,  // enqueue and dequeue with stored data present
        OP_BYPASS     // enqueue and dequeue while empty: data flows straight through
    } op_e;

    function automatic op_e decode_op(input logic push_ok,
                                      input logic pop_ok,
                                      input logic is_empty);
        op_e op;
        op = OP_NONE;
        if (push_ok && pop_ok) op = is_empty ? OP_BYPASS : OP_PUSH_POP;
        else if (push_ok)      op = OP_PUSH;
        else if (pop_ok)       op = OP_POP;
        return op;
    endfunction

endpackage

// File: rtl/bypass_fifo.sv
// bypass_fifo: small synchronous FIFO with a zero-latency bypass when empty.
// Parameters:
//   N     : data width in bits
//   DEPTH : number of storage entries (power of two, >= 2)
// Ports:
//   clk   : clock, state updates on rising edge
//   rst_n : asynchronous active-low reset, clears count, pointers and storage
//   we    : enqueue request, wdata : enqueue data
//   re    : dequeue request
//   rdata : head data (combinational); wdata itself while empty
//   full  : count == DEPTH
//   empty : count == 0
module bypass_fifo
    import bypass_fifo_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [N-1:0] wdata,
    input  logic         re,
    output logic [N-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;

    logic push_ok;
    logic pop_ok;
    op_e  op;

    // Flags come from the registered count only, never from same-cycle requests.
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // Enqueue is evaluated first, so a same-cycle enqueue into an empty FIFO
    // makes the dequeue legal (bypass); a full FIFO drops the write.
    assign push_ok = we && !full;
    assign pop_ok  = re && (!empty || push_ok);
    assign op      = decode_op(push_ok, pop_ok, empty);

    assign rdata = empty ? wdata : mem[rptr];

    // Pointers are PW bits wide and DEPTH is a power of two, so the
    // increments wrap from DEPTH-1 to 0 on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            // NOTE: the storage array sits inside the async reset because the
            // block must come out of reset with every entry cleared; this keeps
            // it in flops rather than a RAM macro, which is fine at this size.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every
            // register samples pre-edge values and ordering inside the block
            // cannot change the result.
            unique case (op)
                OP_PUSH: begin
                    mem[wptr] <= wdata;
                    wptr      <= wptr + PW'(1);
                    count     <= count + (PW+1)'(1);
                end
                OP_POP: begin
                    rptr  <= rptr + PW'(1);
                    count <= count - (PW+1)'(1);
                end
                OP_PUSH_POP: begin
                    mem[wptr] <= wdata;
                    wptr      <= wptr + PW'(1);
                    rptr      <= rptr + PW'(1);
                end
                OP_NONE, OP_BYPASS: begin
                    // Bypassed data is consumed the cycle it arrives; nothing is stored.
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bypass_fifo.sv
// Self-checking bench for bypass_fifo (N=4, DEPTH=2): directed vectors,
// hand-written reset/streaming sequences, and random traffic against a
// queue-based reference model.
module tb_bypass_fifo;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst_n;
    logic         we;
    logic         re;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         full;
    logic         empty;

    int n_checks;
    int n_errors;

    bypass_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wdata (wdata),
        .re    (re),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        logic         we;
        logic         re;
        logic [N-1:0] wdata;
        logic [N-1:0] exp_rdata;
        logic         exp_empty;
        logic         exp_full;
    } vec_t;

    vec_t vecs[16];

    // Reference model: a plain queue. Enqueue first, then dequeue.
    logic [N-1:0] model_q[$];

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Inputs applied at a falling edge; outputs checked 1ns later,
        // i.e. the expected values describe the cycle before the next rising edge.
        vecs[0]  = '{1'b1, 1'b1, 4'h3, 4'h3, 1'b1, 1'b0}; // bypass while empty
        vecs[1]  = '{1'b0, 1'b0, 4'h9, 4'h9, 1'b1, 1'b0}; // bypass stored nothing
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0}; // enqueue 0
        vecs[3]  = '{1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0}; // enqueue 1
        vecs[4]  = '{1'b1, 1'b0, 4'h2, 4'h0, 1'b0, 1'b1}; // full: 2 dropped
        vecs[5]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1}; // dequeue 0
        vecs[6]  = '{1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0}; // dequeue 1
        vecs[7]  = '{1'b0, 1'b0, 4'h6, 4'h6, 1'b1, 1'b0}; // empty again
        vecs[8]  = '{1'b0, 1'b1, 4'h8, 4'h8, 1'b1, 1'b0}; // re while empty, ignored
        vecs[9]  = '{1'b0, 1'b0, 4'hA, 4'hA, 1'b1, 1'b0}; // still empty
        vecs[10] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0}; // refill 0
        vecs[11] = '{1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0}; // refill 1 (wrapped wptr)
        vecs[12] = '{1'b1, 1'b1, 4'h7, 4'h0, 1'b0, 1'b1}; // full + we + re: 7 dropped
        vecs[13] = '{1'b0, 1'b0, 4'h5, 4'h1, 1'b0, 1'b0}; // count 1, head 1
        vecs[14] = '{1'b0, 1'b1, 4'h5, 4'h1, 1'b0, 1'b0}; // dequeue 1
        vecs[15] = '{1'b0, 1'b0, 4'h4, 4'h4, 1'b1, 1'b0}; // empty

        // Reset state: wdata shows through while empty.
        rst_n = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        wdata = 4'h5;
        #1;
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);
        check("reset_rdata", 32'(rdata), 32'h5);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we    = vecs[i].we;
            re    = vecs[i].re;
            wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full",  i), 32'(full),  32'(vecs[i].exp_full));
        end

        // Mid-operation reset: one stored entry, reset pulsed between edges.
        @(negedge clk);
        we = 1'b1; re = 1'b0; wdata = 4'hC;
        @(negedge clk);
        we = 1'b0; wdata = 4'h2;
        #1;
        check("midrst_pre_empty", 32'(empty), 32'd0);
        check("midrst_pre_rdata", 32'(rdata), 32'hC);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_rdata", 32'(rdata), 32'h2);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        re = 1'b1; wdata = 4'hE;
        #1;
        check("midrst_after_empty", 32'(empty), 32'd1);
        check("midrst_after_rdata", 32'(rdata), 32'hE);
        @(negedge clk);
        re = 1'b0;
        #1;
        check("midrst_after2_empty", 32'(empty), 32'd1);

        // Streaming 0..9 with re whenever non-empty; order must hold across wraps.
        begin
            int next_w;
            int next_r;
            int cycles;
            next_w = 0;
            next_r = 0;
            cycles = 0;
            while (next_r < 10 && cycles < 60) begin
                @(negedge clk);
                we    = (next_w < 10);
                wdata = N'(next_w);
                re    = !empty;
                #1;
                check("stream_full", 32'(full), 32'd0);
                if (re) begin
                    check($sformatf("stream_data%0d", next_r), 32'(rdata), 32'(next_r));
                    next_r++;
                end
                if (we && !full) next_w++;
                cycles++;
            end
            check("stream_count", 32'(next_r), 32'd10);
            @(negedge clk);
            we = 1'b0; re = 1'b0;
            #1;
            check("stream_drained", 32'(empty), 32'd1);
        end

        // Random traffic against the queue model, with occasional resets.
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic         m_push;
            logic         m_pop;
            logic [N-1:0] exp_rdata;
            @(negedge clk);
            we    = ($urandom_range(0, 99) < 55);
            re    = ($urandom_range(0, 99) < 50);
            wdata = N'($urandom);
            rst_n = ($urandom_range(0, 99) >= 2);
            #1;
            if (!rst_n) model_q.delete();
            exp_rdata = (model_q.size() > 0) ? model_q[0] : wdata;
            check("rand_rdata", 32'(rdata), 32'(exp_rdata));
            check("rand_empty", 32'(empty), 32'(model_q.size() == 0));
            check("rand_full",  32'(full),  32'(model_q.size() == DEPTH));
            if (rst_n) begin
                m_push = we && (model_q.size() < DEPTH);
                if (m_push) model_q.push_back(wdata);
                m_pop = re && (model_q.size() > 0);
                if (m_pop) void'(model_q.pop_front());
            end
        end

        @(negedge clk);
        rst_n = 1'b1; we = 1'b0; re = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bypass_fifo.md
BYPASS_FIFO -- requirements
Module: bypass_fifo

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of storage entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port we, input, 1 bit: enqueue request.
REQ-006 The block SHALL have port wdata, input, N bits: enqueue data.
REQ-007 The block SHALL have port re, input, 1 bit: dequeue request.
REQ-008 The block SHALL have port rdata, output, N bits: head data, combinational.
REQ-009 The block SHALL have port full, output, 1 bit: asserted when the count equals DEPTH.
REQ-010 The block SHALL have port empty, output, 1 bit: asserted when the count equals 0.

Function
REQ-011 The block SHALL hold a count (0..DEPTH), a write pointer, a read pointer (each log2(DEPTH) bits, wrapping modulo DEPTH) and a DEPTH x N storage array.
REQ-012 full and empty SHALL be decoded from the registered count only; they SHALL NOT depend on same-cycle we or re.
REQ-013 rdata SHALL be mem[rptr] when count>0, and wdata when count==0 (bypass path, zero latency).
REQ-014 An enqueue SHALL be accepted when we && !full; accepted data is written at wptr, except in the bypass case of REQ-016.
REQ-015 A dequeue SHALL be accepted when re && (!empty || (we && !full)); an accepted dequeue delivers rdata in the same cycle.
REQ-016 Bypass: when count==0, we=1 and re=1, wdata SHALL appear on rdata, SHALL be consumed that cycle, and SHALL NOT be stored; count and pointers stay unchanged.
REQ-017 When count>0 and both enqueue and dequeue are accepted, the block SHALL write at wptr, advance both pointers, and keep count unchanged.
REQ-018 Enqueue-only SHALL advance wptr and increment count; dequeue-only SHALL advance rptr and decrement count.
REQ-019 The bypass ordering SHALL be enqueue-then-dequeue: when full, we is ignored (data dropped) even if re=1 in the same cycle; the dequeue still proceeds.
REQ-020 re when empty and we=0 SHALL be ignored with no state change.
REQ-021 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless; FIFO order SHALL be preserved across wraps.

Reset
REQ-022 While rst_n=0, count, wptr and rptr SHALL be 0, giving empty=1 and full=0; the storage array SHALL be cleared to 0.
REQ-023 Assertion of reset mid-operation SHALL discard all stored entries immediately (asynchronous).
REQ-024 During reset, rdata SHALL equal wdata per REQ-013.
REQ-025 The first state update after reset SHALL occur on the first rising clk edge with rst_n=1.

Structure
REQ-026 No shared package is required; N and DEPTH SHALL be module parameters, and the pointer width SHALL be a localparam $clog2(DEPTH).
REQ-027 The block SHALL be a single module with no sub-modules; storage is an inline register array.

Verification
REQ-028 Reset check: hold rst_n=0 with wdata=4'h5 -> empty=1, full=0, rdata=4'h5.
REQ-029 Bypass check: when empty, drive we=1, re=1, wdata=4'h3 -> rdata=4'h3 in the same cycle; after the edge, empty=1 still.
REQ-030 Fill and overflow check: enqueue 0, 1, 2 with re=0 and DEPTH=2 -> full=1 after two edges, value 2 dropped; then dequeue twice -> rdata reads 0, then 1, then empty=1.
REQ-031 Simultaneous operation when full: from a full FIFO holding {0,1}, apply we=1, wdata=7 and re=1 -> rdata=0 dequeued, 7 dropped, count=1, head becomes 1.
REQ-032 Streaming and wrap-around check: enqueue 0..9 continuously, with re asserted on every cycle in which empty=0 -> the dequeued sequence is strictly increasing with no duplicates, pointers wrap several times, and full never asserts.
REQ-033 Mid-operation reset check: with count=1, pulse rst_n low between clock edges -> empty=1 immediately, and the previously stored value is never dequeued.
